// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: bundles the key pulses, the comparator feedback and the
// alarm time/enable/status outputs of alarm_ctrl.
//   master : key-pulse / comparator side (drives keys and alerm_output)
//   slave  : alarm_ctrl (drives alerm_data, alerm_enable, edit_field,
//            ringing, snooze_count)
interface alarm_ctrl_if #(
    parameter int data_width = 18
);
    logic                  key_mode;
    logic                  key_inc;
    logic                  key_snooze;
    logic                  alerm_output;
    logic [data_width-1:0] alerm_data;
    logic                  alerm_enable;
    logic [1:0]            edit_field;
    logic                  ringing;
    logic [1:0]            snooze_count;

    modport master (
        output key_mode, key_inc, key_snooze, alerm_output,
        input  alerm_data, alerm_enable, edit_field, ringing, snooze_count
    );

    modport slave (
        input  key_mode, key_inc, key_snooze, alerm_output,
        output alerm_data, alerm_enable, edit_field, ringing, snooze_count
    );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm time editor, arm/disarm switch and snooze/dismiss
// controller sitting between the key-pulse logic and the alarm comparator.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high
//   bus    - alarm_ctrl_if.slave: key_mode/key_inc/key_snooze pulses and
//            alerm_output in; alerm_data, alerm_enable, edit_field,
//            ringing, snooze_count out (all registered)
//
// state        | meaning
// -------------+--------------------------------------------------------
// S_IDLE       | disarmed, waiting for edit or arm
// S_EDIT_HOUR  | key_inc bumps the hour field
// S_EDIT_MIN   | key_inc bumps the minute field
// S_ARMED      | enable high, waiting for the comparator to ring
// S_RINGING    | alarm sounding, snooze/dismiss accepted
// S_RELEASE    | enable low until the comparator drops alerm_output
module alarm_ctrl #(
    parameter int                    data_width    = 18,
    parameter logic [data_width-1:0] default_alarm = 18'h07000,
    parameter int                    snooze_min    = 5,
    parameter int                    max_snooze    = 3
) (
    input  logic         clock,
    input  logic         reset,
    alarm_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EDIT_HOUR = 3'd1;
    localparam logic [2:0] S_EDIT_MIN  = 3'd2;
    localparam logic [2:0] S_ARMED     = 3'd3;
    localparam logic [2:0] S_RINGING   = 3'd4;
    localparam logic [2:0] S_RELEASE   = 3'd5;

    logic [2:0]            state_q, state_nx;
    logic [data_width-1:0] data_q, data_nx;
    logic [data_width-1:0] base_q, base_nx;
    logic [1:0]            cnt_q, cnt_nx;
    logic                  enable_q;
    logic [1:0]            field_q;
    logic                  ringing_q;

    logic [5:0] hour, minute;
    logic [5:0] hour_inc, minute_inc;
    logic [6:0] minute_sum;
    logic       snz_carry;
    logic [5:0] minute_snz, hour_snz;
    logic       snooze_ok;

    assign hour   = data_q[17:12];
    assign minute = data_q[11:6];

    assign hour_inc   = (hour >= 6'd23)   ? 6'd0 : hour + 6'd1;
    assign minute_inc = (minute >= 6'd59) ? 6'd0 : minute + 6'd1;

    // Snooze add: at most one carry since snooze_min is below 60.
    assign minute_sum = {1'b0, minute} + 7'(snooze_min);
    assign snz_carry  = (minute_sum >= 7'd60);
    assign minute_snz = snz_carry ? 6'(minute_sum - 7'd60) : minute_sum[5:0];
    assign hour_snz   = snz_carry ? hour_inc : hour;

    assign snooze_ok = (cnt_q < 2'(max_snooze));

    always_comb begin
        state_nx = state_q;
        data_nx  = data_q;
        base_nx  = base_q;
        cnt_nx   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.key_mode)      state_nx = S_EDIT_HOUR;
                else if (bus.key_inc)  state_nx = S_ARMED;
            end
            S_EDIT_HOUR: begin
                if (bus.key_mode)      state_nx = S_EDIT_MIN;
                else if (bus.key_inc)  data_nx  = {hour_inc, data_q[11:0]};
            end
            S_EDIT_MIN: begin
                if (bus.key_mode) begin
                    // The edited time becomes the dismiss target.
                    data_nx  = {data_q[17:6], 6'd0};
                    base_nx  = {data_q[17:6], 6'd0};
                    state_nx = S_ARMED;
                end else if (bus.key_inc) begin
                    data_nx = {hour, minute_inc, data_q[5:0]};
                end
            end
            S_ARMED: begin
                if (bus.alerm_output)  state_nx = S_RINGING;
                else if (bus.key_mode) state_nx = S_EDIT_HOUR;
                else if (bus.key_inc)  state_nx = S_IDLE;
            end
            S_RINGING: begin
                if (bus.key_snooze && snooze_ok) begin
                    data_nx  = {hour_snz, minute_snz, data_q[5:0]};
                    cnt_nx   = cnt_q + 2'd1;
                    state_nx = S_RELEASE;
                end else if (bus.key_mode || bus.key_snooze) begin
                    data_nx  = base_q;
                    cnt_nx   = 2'd0;
                    state_nx = S_RELEASE;
                end else if (!bus.alerm_output) begin
                    state_nx = S_ARMED;
                end
            end
            S_RELEASE: begin
                if (!bus.alerm_output) state_nx = S_ARMED;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            data_q    <= default_alarm;
            base_q    <= default_alarm;
            cnt_q     <= 2'd0;
            enable_q  <= 1'b0;
            field_q   <= 2'd0;
            ringing_q <= 1'b0;
        end else begin
            state_q   <= state_nx;
            data_q    <= data_nx;
            base_q    <= base_nx;
            cnt_q     <= cnt_nx;
            enable_q  <= (state_nx == S_ARMED) || (state_nx == S_RINGING);
            field_q   <= (state_nx == S_EDIT_HOUR) ? 2'd1 :
                         (state_nx == S_EDIT_MIN)  ? 2'd2 : 2'd0;
            ringing_q <= (state_nx == S_RINGING);
        end
    end

    assign bus.alerm_data   = data_q;
    assign bus.alerm_enable = enable_q;
    assign bus.edit_field   = field_q;
    assign bus.ringing      = ringing_q;
    assign bus.snooze_count = cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    alarm_ctrl_if #(.data_width(18)) bus ();

    alarm_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        m;
        logic        i;
        logic        s;
        logic        ao;
        logic [17:0] data;
        logic        en;
        logic [1:0]  field;
        logic        ring;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [17:0] hm(input int h, input int m);
        logic [5:0] hh, mm;
        hh = 6'(h);
        mm = 6'(m);
        return {hh, mm, 6'd0};
    endfunction

    task automatic step(input logic r, input logic m, input logic i,
                        input logic s, input logic ao);
        @(negedge clock);
        reset            = r;
        bus.key_mode     = m;
        bus.key_inc      = i;
        bus.key_snooze   = s;
        bus.alerm_output = ao;
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string name, input logic [17:0] act,
                        input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check(input string tag, input logic [17:0] d, input logic en,
                         input logic [1:0] f, input logic rg, input logic [1:0] c);
        chk1({tag, " alerm_data"},   bus.alerm_data,           d);
        chk1({tag, " alerm_enable"}, {17'd0, bus.alerm_enable}, {17'd0, en});
        chk1({tag, " edit_field"},   {16'd0, bus.edit_field},   {16'd0, f});
        chk1({tag, " ringing"},      {17'd0, bus.ringing},      {17'd0, rg});
        chk1({tag, " snooze_count"}, {16'd0, bus.snooze_count}, {16'd0, c});
    endtask

    initial begin
        bus.key_mode     = 1'b0;
        bus.key_inc      = 1'b0;
        bus.key_snooze   = 1'b0;
        bus.alerm_output = 1'b0;

        //                rst m  i  s  ao  data           en f     rg c
        vecs.push_back('{1, 0, 0, 0, 0, 18'h07000, 0, 2'd0, 0, 2'd0}); // reset
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07000, 0, 2'd0, 0, 2'd0}); // idle
        vecs.push_back('{0, 0, 1, 0, 0, 18'h07000, 1, 2'd0, 0, 2'd0}); // arm
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07000, 1, 2'd0, 1, 2'd0}); // ring
        vecs.push_back('{0, 0, 0, 1, 1, 18'h07140, 0, 2'd0, 0, 2'd1}); // snooze 07:05
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07140, 0, 2'd0, 0, 2'd1}); // hold release
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07140, 1, 2'd0, 0, 2'd1}); // re-armed
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07140, 1, 2'd0, 1, 2'd1}); // ring
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07140, 1, 2'd0, 0, 2'd1}); // timeout
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07140, 1, 2'd0, 1, 2'd1}); // ring
        vecs.push_back('{0, 1, 0, 1, 1, 18'h07280, 0, 2'd0, 0, 2'd2}); // mode+snooze
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07280, 1, 2'd0, 0, 2'd2});
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07280, 1, 2'd0, 1, 2'd2});
        vecs.push_back('{0, 1, 0, 0, 1, 18'h07000, 0, 2'd0, 0, 2'd0}); // dismiss
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07000, 1, 2'd0, 0, 2'd0});
        vecs.push_back('{0, 1, 0, 0, 0, 18'h07000, 0, 2'd1, 0, 2'd0}); // edit hour
        vecs.push_back('{0, 0, 1, 0, 0, 18'h08000, 0, 2'd1, 0, 2'd0}); // hour 8
        vecs.push_back('{0, 1, 1, 0, 0, 18'h08000, 0, 2'd2, 0, 2'd0}); // mode wins
        vecs.push_back('{0, 0, 1, 0, 0, 18'h08040, 0, 2'd2, 0, 2'd0}); // minute 1
        vecs.push_back('{0, 0, 0, 1, 0, 18'h08040, 0, 2'd2, 0, 2'd0}); // snooze ignored
        vecs.push_back('{0, 1, 0, 0, 0, 18'h08040, 1, 2'd0, 0, 2'd0}); // armed 08:01
        vecs.push_back('{0, 0, 0, 0, 1, 18'h08040, 1, 2'd0, 1, 2'd0});
        vecs.push_back('{0, 0, 0, 1, 1, 18'h08180, 0, 2'd0, 0, 2'd1}); // 08:06
        vecs.push_back('{1, 0, 0, 1, 1, 18'h07000, 0, 2'd0, 0, 2'd0}); // reset in release
        vecs.push_back('{0, 0, 1, 0, 0, 18'h07000, 1, 2'd0, 0, 2'd0});
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07000, 1, 2'd0, 1, 2'd0});
        vecs.push_back('{1, 0, 0, 0, 1, 18'h07000, 0, 2'd0, 0, 2'd0}); // reset in ring
        vecs.push_back('{0, 0, 1, 0, 1, 18'h07000, 1, 2'd0, 0, 2'd0});
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07000, 1, 2'd0, 1, 2'd0});
        vecs.push_back('{0, 0, 0, 1, 1, 18'h07140, 0, 2'd0, 0, 2'd1});
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07140, 1, 2'd0, 0, 2'd1});
        vecs.push_back('{0, 0, 0, 0, 1, 18'h07140, 1, 2'd0, 1, 2'd1});
        vecs.push_back('{0, 1, 0, 0, 1, 18'h07000, 0, 2'd0, 0, 2'd0}); // base was reset
        vecs.push_back('{0, 0, 0, 0, 0, 18'h07000, 1, 2'd0, 0, 2'd0});

        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].rst, vecs[v].m, vecs[v].i, vecs[v].s, vecs[v].ao);
            check($sformatf("vec%0d", v), vecs[v].data, vecs[v].en,
                  vecs[v].field, vecs[v].ring, vecs[v].cnt);
        end

        // Edit wraps: 7+17 hours wraps to 0, 62 minute steps land on 2.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("edit_enter", 18'h07000, 0, 2'd1, 0, 2'd0);
        for (int k = 0; k < 17; k++) step(0, 0, 1, 0, 0);
        check("hour_wrap", hm(0, 0), 0, 2'd1, 0, 2'd0);
        step(0, 1, 0, 0, 0);
        check("edit_min", hm(0, 0), 0, 2'd2, 0, 2'd0);
        for (int k = 0; k < 62; k++) step(0, 0, 1, 0, 0);
        check("min_wrap", hm(0, 2), 0, 2'd2, 0, 2'd0);
        step(0, 1, 0, 0, 0);
        check("edit_done", 18'h00080, 1, 2'd0, 0, 2'd0);

        // Snooze wrap from 23:58.
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 23; k++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 56; k++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        check("armed_2358", 18'h17E80, 1, 2'd0, 0, 2'd0);
        step(0, 0, 0, 0, 1);
        check("ring_2358", 18'h17E80, 1, 2'd0, 1, 2'd0);
        step(0, 0, 0, 1, 1);
        check("snooze_wrap", 18'h000C0, 0, 2'd0, 0, 2'd1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("release_hold", 18'h000C0, 0, 2'd0, 0, 2'd1);
        step(0, 0, 0, 0, 0);
        check("release_exit", 18'h000C0, 1, 2'd0, 0, 2'd1);

        // Snooze limit: three snoozes then the fourth acts as dismiss.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0, 1);
            check($sformatf("lim_ring%0d", k), hm(7, 5 * (k - 1)), 1, 2'd0, 1, 2'(k - 1));
            step(0, 0, 0, 1, 1);
            if (k < 4)
                check($sformatf("lim_snz%0d", k), hm(7, 5 * k), 0, 2'd0, 0, 2'(k));
            else
                check("lim_dismiss", hm(7, 0), 0, 2'd0, 0, 2'd0);
            step(0, 0, 0, 0, 0);
            check($sformatf("lim_rearm%0d", k), (k < 4) ? hm(7, 5 * k) : hm(7, 0),
                  1, 2'd0, 0, (k < 4) ? 2'(k) : 2'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
